// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU opcodes, the EX/MEM payload and buffer states.
// ALU_OVERFLOW_EN adds an ovf bit to the payload.
package alu_pkg;

    localparam int ALU_XLEN   = 32;
    localparam int ALU_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef struct packed {
        logic [ALU_XLEN-1:0]   result;
        logic                  zero;
        logic [ALU_REG_AW-1:0] rd;
        logic                  illegal;
`ifdef ALU_OVERFLOW_EN
        logic                  ovf;
`endif
    } ex_payload_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_execute_unit_core.sv
// Combinational ALU: (alu_control, a, b, rd) -> EX/MEM payload.
// ALU_OVERFLOW_EN enables signed-overflow detection for add/sub.
module alu_core
    import alu_pkg::*;
(
    input  logic [2:0]            alu_control,
    input  logic [ALU_XLEN-1:0]   a,
    input  logic [ALU_XLEN-1:0]   b,
    input  logic [ALU_REG_AW-1:0] rd,
    output ex_payload_t           payload
);

    logic signed [ALU_XLEN-1:0] sa;
    logic signed [ALU_XLEN-1:0] sb;
    logic signed [ALU_XLEN-1:0] sum;
    logic signed [ALU_XLEN-1:0] diff;

    assign sa   = a;
    assign sb   = b;
    assign sum  = sa + sb;
    assign diff = sa - sb;

`ifdef ALU_OVERFLOW_EN
    // Overflow when both effective operands share a sign the result does not.
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b_eff,
                                        input logic sign_r);
        return (sign_a == sign_b_eff) && (sign_r != sign_a);
    endfunction
`endif

    always_comb begin
        payload    = '0;
        payload.rd = rd;
        case (alu_ctrl_t'(alu_control))
            ALU_ADD: begin
                payload.result = sum;
`ifdef ALU_OVERFLOW_EN
                payload.ovf = signed_ovf(sa[ALU_XLEN-1], sb[ALU_XLEN-1], sum[ALU_XLEN-1]);
`endif
            end
            ALU_SUB: begin
                payload.result = diff;
`ifdef ALU_OVERFLOW_EN
                payload.ovf = signed_ovf(sa[ALU_XLEN-1], ~sb[ALU_XLEN-1], diff[ALU_XLEN-1]);
`endif
            end
            ALU_AND: payload.result = a & b;
            ALU_OR:  payload.result = a | b;
            ALU_SLT: payload.result = {{(ALU_XLEN-1){1'b0}}, (sa < sb)};
            default: payload.illegal = 1'b1;
        endcase
        payload.zero = (payload.result == '0);
    end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: ALU plus a 2-entry elastic output buffer (output register + skid register).
// ALU_OVERFLOW_EN adds the registered ovf output.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int XLEN   = ALU_XLEN,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_control,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [REG_AW-1:0] rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic [REG_AW-1:0] rd_out,
    output logic              illegal
`ifdef ALU_OVERFLOW_EN
    ,
    output logic              ovf
`endif
);

    buf_state_t  state_p1;
    buf_state_t  state_next;
    ex_payload_t core_p0;
    ex_payload_t out_p1;
    ex_payload_t skid_p1;
    logic        vld_p1;
    logic        accept;
    logic        drain;
    logic        load_out;
    logic        out_from_skid;
    logic        load_skid;

    // Stage p0: combinational ALU on the incoming op
    alu_core u_core (
        .alu_control (alu_control),
        .a           (src_a),
        .b           (src_b),
        .rd          (rd_in),
        .payload     (core_p0)
    );

    // in_ready depends only on the state register, never on out_ready
    assign in_ready = (state_p1 != BUF_TWO);
    assign vld_p1   = (state_p1 != BUF_EMPTY);
    assign accept   = in_valid & in_ready;
    assign drain    = vld_p1 & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_p1 <= BUF_EMPTY;
        else       state_p1 <= state_next;
    end

    always_comb begin
        state_next    = state_p1;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state_p1)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next = BUF_ONE;
                        load_out   = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_next = BUF_TWO;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        state_next    = BUF_ONE;
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_next = BUF_EMPTY;
            endcase
        end
    end

    // Stage p1: output and skid registers; a flushed entry must not report illegal
    always_ff @(posedge clk) begin
        if (reset)         out_p1         <= '0;
        else if (flush)    out_p1.illegal <= 1'b0;
        else if (load_out) out_p1         <= out_from_skid ? skid_p1 : core_p0;
    end

    always_ff @(posedge clk) begin
        if (load_skid) skid_p1 <= core_p0;
    end

    assign out_valid = vld_p1;
    assign result    = out_p1.result;
    assign zero      = out_p1.zero;
    assign rd_out    = out_p1.rd;
    assign illegal   = out_p1.illegal;
`ifdef ALU_OVERFLOW_EN
    assign ovf       = out_p1.ovf;
`endif

endmodule

// File: tb/tb_alu_execute_unit.sv
// Self-checking bench for alu_execute_unit: directed scenarios plus a random scoreboard run.
// Define ALU_OVERFLOW_EN to also exercise the ovf port.
module tb_alu_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_out;
    logic        illegal;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_execute_unit dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .rd_in       (rd_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .rd_out      (rd_out),
        .illegal     (illegal)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf         (ovf)
`endif
    );

    function automatic exp_t observed();
        return {result, zero, rd_out, illegal};
    endfunction

    // Reference ALU written from the opcode table, used for random traffic
    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e = '0;
        e.rd = rd;
        case (c)
            3'b000: e.result = a + b;
            3'b001: e.result = a - b;
            3'b010: e.result = a & b;
            3'b011: e.result = a | b;
            3'b101: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        in_valid    = 1'b1;
        alu_control = c;
        src_a       = a;
        src_b       = b;
        rd_in       = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_control = 3'd0; src_a = '0; src_b = '0; rd_in = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (observed() !== exp_t'(0)) $display("FAIL reset_outputs: got %h want 0", observed());
        else n_pass++;
    endtask

    task automatic test_arith();
        logic [2:0]  t_c [10] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b101,
                                  3'b010, 3'b011, 3'b110, 3'b100, 3'b111};
        logic [31:0] t_a [10] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1,
                                  32'h0000_F0F0, 32'h0000_00F0, 32'd123, 32'd9, 32'hFFFF_FFFF};
        logic [31:0] t_b [10] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF,
                                  32'h0000_0FF0, 32'h0000_0F00, 32'd456, 32'd9, 32'd1};
        logic [31:0] t_r [10] = '{32'd12, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,
                                  32'h0000_00F0, 32'h0000_0FF0, 32'd0, 32'd0, 32'd0};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_op(t_c[i], t_a[i], t_b[i], (i == 0) ? 5'd3 : 5'(i + 10));
            sb_q.push_back({t_r[i], (t_r[i] == 32'd0), rd_in, (i >= 7)});
            step();
            e = sb_q.pop_front();
            n_checks++;
            if ({out_valid, observed()} !== {1'b1, e})
                $display("FAIL arith_%0d: got vld=%b %h want vld=1 %h", i, out_valid, observed(), e);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL arith_drained: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b0;
        set_op(3'b000, 32'd10, 32'd20, 5'd7);
        sb_q.push_back({32'd30, 1'b0, 5'd7, 1'b0});
        step();
        set_op(3'b001, 32'd100, 32'd1, 5'd9);
        sb_q.push_back({32'd99, 1'b0, 5'd9, 1'b0});
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_one: got %b want 1", in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_ready_two: got %b want 0", in_ready);
        else n_pass++;
        step();
        step();
        n_checks++;
        if ({out_valid, observed()} !== {1'b1, sb_q[0]})
            $display("FAIL b2b_hold: got vld=%b %h want vld=1 %h", out_valid, observed(), sb_q[0]);
        else n_pass++;
        out_ready = 1'b1;
        e = sb_q.pop_front();
        n_checks++;
        if ({out_valid, observed()} !== {1'b1, e})
            $display("FAIL b2b_first: got vld=%b %h want vld=1 %h", out_valid, observed(), e);
        else n_pass++;
        step();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_back: got %b want 1", in_ready);
        else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if ({out_valid, observed()} !== {1'b1, e})
            $display("FAIL b2b_second: got vld=%b %h want vld=1 %h", out_valid, observed(), e);
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_empty: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_op(3'b000, 32'd1, 32'd2, 5'd1);
        step();
        set_op(3'b000, 32'd3, 32'd4, 5'd2);
        step();
        set_op(3'b011, 32'd5, 32'd6, 5'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, illegal, in_ready} !== 3'b001)
            $display("FAIL flush_two: got vld/ill/rdy=%b%b%b want 001", out_valid, illegal, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_nothing_out: got out_valid=%b want 0", out_valid);
        else n_pass++;
        out_ready = 1'b0;
        set_op(3'b111, 32'd0, 32'd0, 5'd6);
        step();
        n_checks++;
        if ({out_valid, illegal} !== 2'b11)
            $display("FAIL flush_prep_illegal: got vld/ill=%b%b want 11", out_valid, illegal);
        else n_pass++;
        set_op(3'b000, 32'd8, 32'd8, 5'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, illegal} !== 2'b00)
            $display("FAIL flush_one: got vld/ill=%b%b want 00", out_valid, illegal);
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_discard: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_ready = 1'b0;
        set_op(3'b010, 32'hFFFF_FFFF, 32'h1234_5678, 5'd21);
        step();
        set_op(3'b110, 32'd0, 32'd0, 5'd22);
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, observed()} !== {2'b01, exp_t'(0)})
            $display("FAIL reset_mid: got vld=%b rdy=%b %h want vld=0 rdy=1 0", out_valid, in_ready, observed());
        else n_pass++;
        out_ready = 1'b1;
        set_op(3'b011, 32'h0000_1000, 32'h0000_0001, 5'd30);
        sb_q.push_back({32'h0000_1001, 1'b0, 5'd30, 1'b0});
        step();
        in_valid = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if ({out_valid, observed()} !== {1'b1, e})
            $display("FAIL reset_mid_recover: got vld=%b %h want vld=1 %h", out_valid, observed(), e);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        exp_t  e;
        exp_t  held = '0;
        logic  hold_prev = 1'b0;
        logic [31:0] a;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hold_prev) begin
                n_checks++;
                if ({out_valid, observed()} !== {1'b1, held})
                    $display("FAIL rand_stable_%0d: got vld=%b %h want vld=1 %h", cyc, out_valid, observed(), held);
                else n_pass++;
            end
            a = $urandom;
            set_op(3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                   5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL rand_extra_%0d: got output %h want none", cyc, observed());
                end else begin
                    e = sb_q.pop_front();
                    if (observed() !== e)
                        $display("FAIL rand_out_%0d: got %h want %h", cyc, observed(), e);
                    else n_pass++;
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = observed();
            if (in_valid && in_ready) sb_q.push_back(model(alu_control, src_a, src_b, rd_in));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                n_checks++;
                if (observed() !== e) $display("FAIL rand_drain_%0d: got %h want %h", k, observed(), e);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if ({sb_q.size() == 0, out_valid} !== 2'b10)
            $display("FAIL rand_final: got left=%0d vld=%b want left=0 vld=0", sb_q.size(), out_valid);
        else n_pass++;
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic test_overflow();
        logic [2:0]  t_c [4] = '{3'b000, 3'b001, 3'b000, 3'b010};
        logic [31:0] t_a [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] t_b [4] = '{32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] t_r [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFF};
        logic        t_o [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(t_c[i], t_a[i], t_b[i], 5'd1);
            step();
            n_checks++;
            if ({out_valid, result, ovf} !== {1'b1, t_r[i], t_o[i]})
                $display("FAIL ovf_%0d: got vld=%b res=%h ovf=%b want vld=1 res=%h ovf=%b",
                         i, out_valid, result, ovf, t_r[i], t_o[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef ALU_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
